// File: rtl/load_store_unit.sv
// Load/store unit: core request -> word-addressed req/gnt/rvalid data bus, byte lanes and load extension.
// Optional LSU_MISALIGN_TRAP_EN: misaligned requests complete immediately with LsuMisaligned=1 and no bus access.
module load_store_unit #(
  parameter int unsigned BIT_COUNT = 32,
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   LsuReq,
  input  logic                   LsuWrite,
  input  logic [1:0]             LsuSize,
  input  logic                   LsuUnsigned,
  input  logic [BIT_COUNT-1:0]   LsuAdr,
  input  logic [BIT_COUNT-1:0]   LsuWriteData,
  output logic                   LsuStall,
  output logic                   LsuDone,
  output logic [BIT_COUNT-1:0]   LsuReadData,
  output logic                   LsuMisaligned,
  output logic                   MemReq,
  output logic                   MemWrite,
  output logic [BIT_COUNT-1:0]   MemAdr,
  output logic [WORD_SIZE/8-1:0] ByteEn,
  output logic [WORD_SIZE-1:0]   MemWriteData,
  input  logic                   MemGnt,
  input  logic                   MemRValid,
  input  logic [WORD_SIZE-1:0]   MemReadData
);

  localparam int unsigned BE_W = WORD_SIZE / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e                 state_q;
  logic                   req_q;
  logic                   write_q;
  logic [BIT_COUNT-1:0]   adr_q;
  logic [BE_W-1:0]        be_q;
  logic [WORD_SIZE-1:0]   wdata_q;
  logic                   done_q;
  logic                   mis_q;
  logic [BIT_COUNT-1:0]   rdata_q;
  logic [1:0]             size_q;
  logic                   uns_q;
  logic [1:0]             off_q;

  logic [1:0]             a;
  logic [BE_W-1:0]        be_d;
  logic [WORD_SIZE-1:0]   wdata_d;
  logic [1:0]             off_d;
  logic                   trap_d;
  logic [WORD_SIZE-1:0]   shifted;
  logic [BIT_COUNT-1:0]   rdata_d;

  assign a = LsuAdr[1:0];

  // Lane offset is pre-aligned to the access size, so misaligned low bits are dropped here.
  always_comb begin
    be_d    = '0;
    wdata_d = '0;
    off_d   = '0;
    case (LsuSize)
      2'b00: begin
        be_d    = 4'b0001 << a;
        wdata_d = {4{LsuWriteData[7:0]}};
        off_d   = a;
      end
      2'b01: begin
        be_d    = 4'b0011 << {a[1], 1'b0};
        wdata_d = {2{LsuWriteData[15:0]}};
        off_d   = {a[1], 1'b0};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = LsuWriteData[31:0];
        off_d   = 2'b00;
      end
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_d = ((LsuSize == 2'b01) && a[0]) || (LsuSize[1] && (a != 2'b00));
`else
  assign trap_d = 1'b0;
`endif

  assign shifted = MemReadData >> {off_q, 3'b000};

  always_comb begin
    rdata_d = '0;
    case (size_q)
      2'b00:   rdata_d = uns_q ? BIT_COUNT'(shifted[7:0])
                               : BIT_COUNT'($signed(shifted[7:0]));
      2'b01:   rdata_d = uns_q ? BIT_COUNT'(shifted[15:0])
                               : BIT_COUNT'($signed(shifted[15:0]));
      default: rdata_d = uns_q ? BIT_COUNT'(shifted[31:0])
                               : BIT_COUNT'($signed(shifted[31:0]));
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      write_q <= 1'b0;
      adr_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      off_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          mis_q  <= 1'b0;
          if (LsuReq) begin
            if (trap_d) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              mis_q   <= 1'b1;
              rdata_q <= '0;
            end else begin
              state_q <= REQ;
              req_q   <= 1'b1;
              write_q <= LsuWrite;
              adr_q   <= {LsuAdr[BIT_COUNT-1:2], 2'b00};
              be_q    <= be_d;
              wdata_q <= wdata_d;
              size_q  <= LsuSize;
              uns_q   <= LsuUnsigned;
              off_q   <= off_d;
            end
          end
        end
        REQ: begin
          if (MemGnt) begin
            req_q <= 1'b0;
            if (write_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              rdata_q <= '0;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (MemRValid) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            rdata_q <= rdata_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          mis_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign LsuStall      = ((state_q == IDLE) && LsuReq) || (state_q == REQ) || (state_q == WAIT);
  assign LsuDone       = done_q;
  assign LsuReadData   = rdata_q;
  assign LsuMisaligned = mis_q;
  assign MemReq        = req_q;
  assign MemWrite      = write_q;
  assign MemAdr        = adr_q;
  assign ByteEn        = be_q;
  assign MemWriteData  = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a byte-lane arithmetic model.
// Honours LSU_MISALIGN_TRAP_EN the same way the design does.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        LsuReq, LsuWrite, LsuUnsigned;
  logic [1:0]  LsuSize;
  logic [31:0] LsuAdr, LsuWriteData;
  logic        LsuStall, LsuDone, LsuMisaligned;
  logic [31:0] LsuReadData;
  logic        MemReq, MemWrite;
  logic [31:0] MemAdr, MemWriteData, MemReadData;
  logic [3:0]  ByteEn;
  logic        MemGnt, MemRValid;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.BIT_COUNT(32), .WORD_SIZE(32)) dut (
    .clk(clk), .reset(reset),
    .LsuReq(LsuReq), .LsuWrite(LsuWrite), .LsuSize(LsuSize), .LsuUnsigned(LsuUnsigned),
    .LsuAdr(LsuAdr), .LsuWriteData(LsuWriteData),
    .LsuStall(LsuStall), .LsuDone(LsuDone), .LsuReadData(LsuReadData),
    .LsuMisaligned(LsuMisaligned),
    .MemReq(MemReq), .MemWrite(MemWrite), .MemAdr(MemAdr), .ByteEn(ByteEn),
    .MemWriteData(MemWriteData), .MemGnt(MemGnt), .MemRValid(MemRValid),
    .MemReadData(MemReadData)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic int unsigned base_of(input logic [1:0] sz, input logic [31:0] adr);
    int unsigned n = nbytes(sz);
    return (int'(adr[1:0]) / n) * n;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] adr);
    logic [3:0] be = '0;
    int unsigned b0 = base_of(sz, adr);
    for (int unsigned b = 0; b < 4; b++)
      if (b >= b0 && b < b0 + nbytes(sz)) be[b] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] w = '0;
    for (int unsigned b = 0; b < 4; b++) w[8*b +: 8] = d[8*(b % nbytes(sz)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_rdata(input logic [1:0] sz, input logic uns,
                                              input logic [31:0] adr, input logic [31:0] rd);
    logic [63:0] r = '0;
    int unsigned n = nbytes(sz);
    int unsigned b0 = base_of(sz, adr);
    for (int unsigned k = 0; k < n; k++) r = r | (64'(rd[8*(b0+k) +: 8]) << (8*k));
    if (!uns && r[8*n-1]) r = r | ~((64'd1 << (8*n)) - 64'd1);
    return r[31:0];
  endfunction

  task automatic do_access(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] adr, input logic [31:0] wd, input logic [31:0] rd,
                           input int unsigned gd, input int unsigned rvd);
    int unsigned cyc = 0;
    logic trap = 1'b0;
    logic [3:0] ebe = model_be(sz, adr);
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (int'(adr[1:0]) % nbytes(sz)) != 0;
`endif
    LsuReq = 1'b1; LsuWrite = wr; LsuSize = sz; LsuUnsigned = uns;
    LsuAdr = adr; LsuWriteData = wd;
    #1;
    check("stall_idle_req", LsuStall, 1'b1);
    @(posedge clk); #1; cyc++;
    if (trap) begin
      check("trap_done", LsuDone, 1'b1);
      check("trap_mis", LsuMisaligned, 1'b1);
      check("trap_noreq", MemReq, 1'b0);
      check("trap_rdata", LsuReadData, 32'h0);
      check("trap_stall", LsuStall, 1'b0);
      LsuReq = 1'b0;
      @(posedge clk); #1;
      check("trap_pulse", LsuDone, 1'b0);
      return;
    end
    check("req", MemReq, 1'b1);
    check("adr", MemAdr, {adr[31:2], 2'b00});
    check("be", ByteEn, ebe);
    check("we", MemWrite, wr);
    if (wr) check("wdata", MemWriteData, model_wdata(sz, wd));
    check("nodone_req", LsuDone, 1'b0);
    for (int unsigned i = 0; i < gd; i++) begin
      @(posedge clk); #1; cyc++;
      check("hold_req", MemReq, 1'b1);
      check("hold_adr", MemAdr, {adr[31:2], 2'b00});
      check("hold_be", ByteEn, ebe);
      check("hold_stall", LsuStall, 1'b1);
      if (wr) check("hold_wdata", MemWriteData, model_wdata(sz, wd));
    end
    MemGnt = 1'b1;
    @(posedge clk); #1; cyc++;
    MemGnt = 1'b0;
    check("req_drop", MemReq, 1'b0);
    if (!wr) begin
      check("wait_stall", LsuStall, 1'b1);
      check("wait_nodone", LsuDone, 1'b0);
      for (int unsigned i = 0; i < rvd; i++) begin
        @(posedge clk); #1; cyc++;
        check("wait_hold", LsuStall, 1'b1);
      end
      MemRValid = 1'b1; MemReadData = rd;
      @(posedge clk); #1; cyc++;
      MemRValid = 1'b0; MemReadData = $urandom;
      check("rdata", LsuReadData, model_rdata(sz, uns, adr, rd));
    end
    check("done", LsuDone, 1'b1);
    check("done_stall", LsuStall, 1'b0);
    check("mis_clear", LsuMisaligned, 1'b0);
    check("latency", cyc, wr ? 2 + gd : 3 + gd + rvd);
    LsuReq = 1'b0;
    @(posedge clk); #1;
    check("pulse", LsuDone, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; LsuReq = 1'b0; LsuWrite = 1'b0; LsuSize = 2'b00; LsuUnsigned = 1'b0;
    LsuAdr = '0; LsuWriteData = '0; MemGnt = 1'b0; MemRValid = 1'b0; MemReadData = '0;
    #12;
    check("rst_req", MemReq, 1'b0);
    check("rst_done", LsuDone, 1'b0);
    check("rst_adr", MemAdr, 32'h0);
    check("rst_be", ByteEn, 4'h0);
    check("rst_rdata", LsuReadData, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    do_access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FF1234, 0, 0);
    check("plan_sbyte", model_rdata(2'b00, 1'b0, 32'h103, 32'h80FF1234), 32'hFFFFFF80);
    do_access(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, 32'h0, 0, 0);
    do_access(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h80010000, 0, 0);
    do_access(1'b1, 2'b10, 1'b0, 32'h300, 32'hDEADBEEF, 32'h0, 3, 0);
    do_access(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h12345678, 0, 0);

    // Reset asserted while waiting for read data, then a stray rvalid.
    LsuReq = 1'b1; LsuWrite = 1'b0; LsuSize = 2'b10; LsuAdr = 32'h400;
    @(posedge clk); #1;
    MemGnt = 1'b1;
    @(posedge clk); #1;
    MemGnt = 1'b0; LsuReq = 1'b0;
    reset = 1'b0; #1;
    check("arst_req", MemReq, 1'b0);
    check("arst_we", MemWrite, 1'b0);
    check("arst_adr", MemAdr, 32'h0);
    check("arst_be", ByteEn, 4'h0);
    check("arst_wdata", MemWriteData, 32'h0);
    check("arst_stall", LsuStall, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1; MemRValid = 1'b1; MemReadData = 32'hCAFEF00D;
    for (int unsigned i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stray_nodone", LsuDone, 1'b0);
      check("stray_noreq", MemReq, 1'b0);
      check("stray_rdata", LsuReadData, 32'h0);
    end
    MemRValid = 1'b0;

    for (int unsigned t = 0; t < 60; t++) begin
      do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory interface stage directly downstream of the compute core.
- Consumes the core's load/store request (enable, write, address, write data) and drives a word-addressed data-memory bus with a req/gnt/rvalid handshake.
- Generates byte enables and replicates store data across lanes. Extracts load data and sign/zero-extends it to BIT_COUNT.
- Stalls the core until the access completes.

Parameters:
BIT_COUNT  32  core datapath width (32 or 64)
WORD_SIZE  32  memory bus data width; only 32 supported

Ports:
clk  input  1  clock; all state on rising edge
reset  input  1  asynchronous, active-low reset
LsuReq  input  1  core requests an access; held stable while LsuStall=1
LsuWrite  input  1  1=store, 0=load
LsuSize  input  2  00=byte, 01=half, 10=word; 11 treated as word
LsuUnsigned  input  1  load zero-extends when 1, sign-extends when 0
LsuAdr  input  BIT_COUNT  byte address
LsuWriteData  input  BIT_COUNT  store data; low bits used
LsuStall  output  1  core must hold its request/PC
LsuDone  output  1  one-cycle completion pulse
LsuReadData  output  BIT_COUNT  extended load result; valid while LsuDone=1
LsuMisaligned  output  1  misaligned-access flag, qualified by LsuDone
MemReq  output  1  bus request
MemWrite  output  1  bus write
MemAdr  output  BIT_COUNT  word-aligned address, {LsuAdr[BIT_COUNT-1:2],2'b00}
ByteEn  output  WORD_SIZE/8  lane enables
MemWriteData  output  WORD_SIZE  lane-replicated store data
MemGnt  input  1  bus accepted request this cycle
MemRValid  input  1  read data valid (loads only)
MemReadData  input  WORD_SIZE  read data

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - MemReq, MemWrite, LsuDone and LsuMisaligned are 0.
  - MemAdr, ByteEn, MemWriteData and LsuReadData are 0.
  - A reset mid-access abandons the access. Any later MemGnt or MemRValid is ignored until a new request is issued.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If LsuReq=1: latch write, size, unsigned, address and store data; drive the registered bus outputs; go to REQ.
  - MemRValid and MemGnt are ignored.
- REQ:
  - MemReq=1; MemAdr, ByteEn, MemWrite and MemWriteData are held constant.
  - On MemGnt: a store goes to DONE; a load goes to WAIT.
  - MemReq drops in the cycle after MemGnt.
- WAIT:
  - On MemRValid: capture MemReadData, compute LsuReadData, go to DONE.
  - MemRValid in the same cycle as MemGnt is not expected and is ignored.
- DONE:
  - Lasts exactly one cycle, then goes to IDLE.
  - LsuDone=1, LsuStall=0. A new LsuReq is sampled only in IDLE.
- LsuStall = LsuReq in IDLE, or state is REQ or WAIT. LsuStall=0 in DONE.
- Minimum latency, request sample to LsuDone, assuming gnt in the first REQ cycle:
  - Store: 2 cycles.
  - Load: 3 cycles, with rvalid one cycle after gnt.
- Byte enables, with a = LsuAdr[1:0]:
  - Byte: 4'b0001<<a.
  - Half: 4'b0011<<(2*a[1]).
  - Word: 4'b1111.
- Store data: byte replicated {4{d[7:0]}}; half replicated {2{d[15:0]}}; word unchanged.
- Load data:
  - Shift MemReadData right by 8*a (half uses 16*a[1]).
  - Take the low 8, 16 or 32 bits.
  - Sign- or zero-extend to BIT_COUNT. With BIT_COUNT=64, a word load is extended per LsuUnsigned.
- Misaligned means: half with a[0]=1, or word with a!=0.

Optional Feature:
Macro LSU_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned request issues no bus transaction (MemReq stays 0).
  - Path is IDLE -> DONE. LsuDone=1 and LsuMisaligned=1 for that cycle; LsuReadData=0.
- Undefined:
  - The offending low address bits are forced to 0 (half ignores a[0]; word ignores a[1:0]) and the access proceeds normally.
  - LsuMisaligned is tied to 0.

Test Plan:
- Signed byte load, LsuAdr=0x103, MemReadData=0x80FF1234:
  - ByteEn=1000, MemAdr=0x100.
  - LsuReadData=0xFFFFFF80; LsuDone 3 cycles after request.
- Half store, LsuAdr=0x202, LsuWriteData=0x0000ABCD:
  - MemWrite=1, MemAdr=0x200, ByteEn=1100, MemWriteData=0xABCDABCD.
  - LsuDone 2 cycles after request; no rvalid needed.
- Unsigned half load, LsuAdr=0x102, MemReadData=0x80010000:
  - LsuReadData=0x00008001.
- MemGnt withheld 3 cycles:
  - MemReq, MemAdr, ByteEn and MemWriteData stay constant.
  - LsuStall=1 throughout; completion follows the grant.
- Reset pulled low while in WAIT, followed by a stray MemRValid=1:
  - All outputs 0 and state IDLE.
  - No LsuDone pulse.
- Word load at LsuAdr=0x101:
  - With LSU_MISALIGN_TRAP_EN: no MemReq; LsuDone=1 and LsuMisaligned=1 one cycle after request.
  - Without it: MemAdr=0x100, ByteEn=1111, normal completion.
